// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-way round-robin arbiter with registered grant and hold timer
//
// Purpose:
//   Shares one downstream resource between eight requesters. A grant is
//   issued in IDLE to the first requester found scanning from the rotating
//   priority pointer. The grant is held until the owner pulses done, drops
//   its request, or the optional hold timer runs out.
//
// Parameters:
//   HOLD_MAX   maximum grant length in cycles (1..255); 0 disables the timer
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[7:0]   request vector, bit i = requester i
//   done       release strobe from the current owner (ignored when idle)
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_idx    binary index of the granted requester, zero when idle
//   gnt_valid  high while a grant is active (OR of gnt)
//   expired    one-cycle pulse after a release caused only by the timer

module rr_arbiter_8 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       expired
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   // Timer fires when the counter reaches HOLD_MAX-1: the counter is 0 in the
   // first visible grant cycle, so this yields exactly HOLD_MAX grant cycles.
   localparam bit         TIMER_EN  = (HOLD_MAX != 0);
   localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

   state_t     state_q,    state_d;
   logic [2:0] ptr_q,      ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [2:0] owner_q,    owner_d;
   logic [7:0] gnt_q,      gnt_d;
   logic [2:0] gnt_idx_q,  gnt_idx_d;
   logic       expired_q,  expired_d;

   logic       pick_found;
   logic [2:0] pick_idx;
   logic       rel_done;
   logic       rel_drop;
   logic       rel_timer;
   logic       release_now;

   // Rotating priority search. Walking the offsets from farthest to nearest
   // lets the nearest set bit overwrite earlier hits, so the result is the
   // first requester at or after ptr (mod 8).
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         if (req[ptr_q + 3'(k)]) begin
            pick_found = 1'b1;
            pick_idx   = ptr_q + 3'(k);
         end
      end
   end

   assign rel_done    = done;
   assign rel_drop    = ~req[owner_q];
   assign rel_timer   = TIMER_EN && (hold_cnt_q == HOLD_LAST);
   assign release_now = rel_done | rel_drop | rel_timer;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      expired_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // done is deliberately not looked at here
            if (pick_found) begin
               owner_d    = pick_idx;
               gnt_d      = 8'b0000_0001 << pick_idx;
               gnt_idx_d  = pick_idx;
               hold_cnt_d = 8'd0;
               state_d    = S_GRANT;
            end
         end

         S_GRANT: begin
            if (release_now) begin
               gnt_d     = 8'h00;
               gnt_idx_d = 3'd0;
               ptr_d     = owner_q + 3'd1;
               state_d   = S_IDLE;
               // Only a pure timeout is reported; any owner-side release wins.
               expired_d = rel_timer & ~rel_done & ~rel_drop;
            end else if (hold_cnt_q != 8'hFF) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d   = S_IDLE;
            gnt_d     = 8'h00;
            gnt_idx_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= 3'd0;
         hold_cnt_q <= 8'd0;
         owner_q    <= 3'd0;
         gnt_q      <= 8'h00;
         gnt_idx_q  <= 3'd0;
         expired_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         expired_q  <= expired_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = |gnt_q;
   assign expired   = expired_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - scoreboard bench for rr_arbiter_8 with a cycle reference model

module tb_rr_arbiter_8;

   localparam int H = 4;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       expired;

   rr_arbiter_8 #(.HOLD_MAX(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .expired   (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       expired;
   } exp_t;

   exp_t exp_q[$];
   int   grant_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model: a grant is "busy with owner o, already shown for held cycles"
   bit m_busy  = 0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_held  = 0;

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model(input logic [7:0] r, input logic d, input logic rs);
      exp_t e;
      bit   drp;
      bit   tmr;
      e = '0;
      if (rs) begin
         m_busy  = 0;
         m_ptr   = 0;
         m_held  = 0;
         m_owner = 0;
      end else if (!m_busy) begin
         if (r != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               if (r[(m_ptr + k) % 8]) begin
                  m_owner = (m_ptr + k) % 8;
                  break;
               end
            end
            m_busy = 1;
            m_held = 1;
            grant_q.push_back(m_owner);
         end
      end else begin
         drp = !r[m_owner];
         tmr = (H != 0) && (m_held == H);
         if (d || drp || tmr) begin
            m_busy    = 0;
            m_ptr     = (m_owner + 1) % 8;
            e.expired = tmr && !d && !drp;
         end else begin
            m_held = (m_held < 256) ? m_held + 1 : m_held;
         end
      end
      if (m_busy) begin
         e.gnt   = 8'(1 << m_owner);
         e.idx   = 3'(m_owner);
         e.valid = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs on the falling edge and record what the DUT
   // must show after the following rising edge.
   task automatic step(input logic [7:0] r, input logic d, input logic rs);
      @(negedge clk);
      req  = r;
      done = d;
      rst  = rs;
      model(r, d, rs);
   endtask

   // Monitor: samples outputs 2 time units after each rising edge.
   initial begin
      exp_t e;
      logic prev_v;
      int   want_idx;
      prev_v = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",       int'(gnt),       int'(e.gnt));
            chk("gnt_idx",   int'(gnt_idx),   int'(e.idx));
            chk("gnt_valid", int'(gnt_valid), int'(e.valid));
            chk("expired",   int'(expired),   int'(e.expired));
            if (gnt_valid && !prev_v) begin
               if (grant_q.size() == 0) begin
                  chk("grant_order_unexpected", int'(gnt_idx), -1);
               end else begin
                  want_idx = grant_q.pop_front();
                  chk("grant_order", int'(gnt_idx), want_idx);
               end
            end
         end
         prev_v = gnt_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;

      // Reset and idle, including done while idle
      repeat (2) step(8'h00, 1'b0, 1'b1);
      repeat (5) step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0);

      // Full rotation 0..7,0 with done one cycle into each grant
      for (int i = 0; i < 9; i++) begin
         step(8'hFF, 1'b0, 1'b0);
         step(8'hFF, 1'b1, 1'b0);
      end

      // Serve 0..6 so ptr lands on 7, then wrap past 7 to 0 and skip to 2
      step(8'hFF, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(8'hFF, 1'b0, 1'b0);
         step(8'hFF, 1'b1, 1'b0);
      end
      step(8'h05, 1'b0, 1'b0);
      step(8'h05, 1'b1, 1'b0);
      step(8'h05, 1'b0, 1'b0);
      step(8'h05, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0);

      // Hold timer: H grant cycles, expired pulse, bubble, regrant
      repeat (13) step(8'h08, 1'b0, 1'b0);
      repeat (2) step(8'h00, 1'b0, 1'b0);

      // Drop + done on the timer edge: normal release, ptr -> 4
      step(8'h08, 1'b0, 1'b0);
      repeat (H - 1) step(8'h08, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      step(8'hFF, 1'b0, 1'b0);
      step(8'hFF, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0);

      // Reset while gnt = 0x20, then next grant from ptr 0
      step(8'h20, 1'b0, 1'b0);
      step(8'h20, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 1'b1);
      step(8'hFF, 1'b0, 1'b0);
      step(8'hFF, 1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] r;
         logic       d;
         logic       rs;
         r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 2) == 0) r = r | 8'($urandom) | 8'($urandom);
         d  = ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 60) == 0);
         step(r, d, rs);
      end

      step(8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      chk("exp_q_drained",   exp_q.size(),   0);
      chk("grant_q_drained", grant_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
